// File: rtl/slc3_control_fsm.sv
//------------------------------------------------------------------------------
// Module      : slc3_control_fsm
// Description : SLC-3 control unit. Sequences fetch, decode and execute for
//               ADD/AND/NOT/LDR/STR/LD/ST/LEA/JSR/JMP/BR/PSE. Memory accesses
//               last a fixed number of cycles or wait on a ready handshake.
//               All outputs are decoded from the registered state.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module slc3_control_fsm #(
    parameter int MEM_WAIT = 3,   // 1..15
    parameter int MEM_MODE = 0,   // 0 = fixed wait, 1 = mem_rdy_i handshake
    parameter int PAUSE_EN = 1    // 1 = PSE pauses, 0 = PSE is illegal
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [15:0] ir,
    input  logic       ben,
    input  logic       continue_i,
    input  logic       run_i,
    input  logic       mem_rdy_i,
    output logic       ld_mar,
    output logic       ld_mdr,
    output logic       ld_ir,
    output logic       ld_pc,
    output logic       ld_led,
    output logic       ld_reg,
    output logic       ld_cc,
    output logic       gate_pc,
    output logic       gate_mdr,
    output logic       gate_alu,
    output logic       gate_marmux,
    output logic [1:0] pcmux,
    output logic [1:0] ALUK,
    output logic       sr1,
    output logic       sr2mux,
    output logic       addr1mux,
    output logic [1:0] addr2mux,
    output logic       dr_sel,
    output logic       mem_mem_ena,
    output logic       mem_wr_ena,
    output logic       illegal_o
);

    typedef enum logic [4:0] {
        S_HALTED   = 5'd0,
        S_FETCH    = 5'd1,
        S_MEM_RD   = 5'd2,
        S_LOAD_IR  = 5'd3,
        S_DECODE   = 5'd4,
        S_ADD      = 5'd5,
        S_AND      = 5'd6,
        S_NOT      = 5'd7,
        S_LDR_ADDR = 5'd8,
        S_STR_ADDR = 5'd9,
        S_LD_ADDR  = 5'd10,
        S_ST_ADDR  = 5'd11,
        S_LD_RD    = 5'd12,
        S_LD_WB    = 5'd13,
        S_ST_MDR   = 5'd14,
        S_ST_WR    = 5'd15,
        S_LEA      = 5'd16,
        S_JSR_SAVE = 5'd17,
        S_JSR_PC   = 5'd18,
        S_JMP      = 5'd19,
        S_BR       = 5'd20,
        S_BR_TAKE  = 5'd21,
        S_PAUSE1   = 5'd22,
        S_PAUSE2   = 5'd23
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic       w_mem_state;
    logic       w_mem_done;
    logic       w_unused;

    // Only the opcode, JSR mode bit and immediate flag of IR steer the FSM
    assign w_unused    = &{1'b0, ir[10:6], ir[4:0]};

    assign w_mem_state = (r_state == S_MEM_RD) || (r_state == S_LD_RD) ||
                         (r_state == S_ST_WR);
    assign w_mem_done  = (MEM_MODE != 0) ? mem_rdy_i
                                         : (r_cnt == 4'(MEM_WAIT - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_HALTED;
        end else begin
            r_state <= w_next;
        end
    end

    // Shared wait counter: counts cycles spent in a memory state, zero elsewhere
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 4'd0;
        end else if ((MEM_MODE == 0) && w_mem_state && !w_mem_done) begin
            r_cnt <= r_cnt + 4'd1;
        end else begin
            r_cnt <= 4'd0;
        end
    end

    // Next-state selection and Moore output decode
    always_comb begin
        w_next      = r_state;
        ld_mar      = 1'b0;
        ld_mdr      = 1'b0;
        ld_ir       = 1'b0;
        ld_pc       = 1'b0;
        ld_led      = 1'b0;
        ld_reg      = 1'b0;
        ld_cc       = 1'b0;
        gate_pc     = 1'b0;
        gate_mdr    = 1'b0;
        gate_alu    = 1'b0;
        gate_marmux = 1'b0;
        pcmux       = 2'b00;
        ALUK        = 2'b00;
        sr1         = 1'b0;
        sr2mux      = 1'b0;
        addr1mux    = 1'b0;
        addr2mux    = 2'b00;
        dr_sel      = 1'b0;
        mem_mem_ena = 1'b0;
        mem_wr_ena  = 1'b0;
        illegal_o   = 1'b0;

        case (r_state)
            S_HALTED: begin
                if (run_i) w_next = S_FETCH;
            end
            S_FETCH: begin
                gate_pc = 1'b1;
                ld_mar  = 1'b1;
                ld_pc   = 1'b1;
                w_next  = S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_mem_ena = 1'b1;
                ld_mdr      = 1'b1;
                if (w_mem_done) w_next = S_LOAD_IR;
            end
            S_LOAD_IR: begin
                gate_mdr = 1'b1;
                ld_ir    = 1'b1;
                w_next   = S_DECODE;
            end
            S_DECODE: begin
                case (ir[15:12])
                    4'b0000: w_next = S_BR;
                    4'b0001: w_next = S_ADD;
                    4'b0010: w_next = S_LD_ADDR;
                    4'b0011: w_next = S_ST_ADDR;
                    4'b0100: w_next = S_JSR_SAVE;
                    4'b0101: w_next = S_AND;
                    4'b0110: w_next = S_LDR_ADDR;
                    4'b0111: w_next = S_STR_ADDR;
                    4'b1001: w_next = S_NOT;
                    4'b1100: w_next = S_JMP;
                    4'b1110: w_next = S_LEA;
                    4'b1101: begin
                        if (PAUSE_EN != 0) begin
                            w_next = S_PAUSE1;
                        end else begin
                            illegal_o = 1'b1;
                            w_next    = S_FETCH;
                        end
                    end
                    default: begin
                        illegal_o = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_ADD, S_AND: begin
                gate_alu = 1'b1;
                ld_reg   = 1'b1;
                ld_cc    = 1'b1;
                sr1      = 1'b1;
                sr2mux   = ir[5];
                ALUK     = (r_state == S_AND) ? 2'b01 : 2'b00;
                w_next   = S_FETCH;
            end
            S_NOT: begin
                gate_alu = 1'b1;
                ld_reg   = 1'b1;
                ld_cc    = 1'b1;
                sr1      = 1'b1;
                ALUK     = 2'b10;
                w_next   = S_FETCH;
            end
            S_LDR_ADDR, S_STR_ADDR: begin
                gate_marmux = 1'b1;
                ld_mar      = 1'b1;
                addr1mux    = 1'b1;
                addr2mux    = 2'b01;
                sr1         = 1'b1;
                w_next      = (r_state == S_LDR_ADDR) ? S_LD_RD : S_ST_MDR;
            end
            S_LD_ADDR, S_ST_ADDR: begin
                gate_marmux = 1'b1;
                ld_mar      = 1'b1;
                addr2mux    = 2'b10;
                sr1         = 1'b1;
                w_next      = (r_state == S_LD_ADDR) ? S_LD_RD : S_ST_MDR;
            end
            S_LD_RD: begin
                mem_mem_ena = 1'b1;
                ld_mdr      = 1'b1;
                if (w_mem_done) w_next = S_LD_WB;
            end
            S_LD_WB: begin
                gate_mdr = 1'b1;
                ld_reg   = 1'b1;
                ld_cc    = 1'b1;
                w_next   = S_FETCH;
            end
            S_ST_MDR: begin
                ALUK     = 2'b11;
                gate_alu = 1'b1;
                ld_mdr   = 1'b1;
                w_next   = S_ST_WR;
            end
            S_ST_WR: begin
                mem_mem_ena = 1'b1;
                mem_wr_ena  = 1'b1;
                if (w_mem_done) w_next = S_FETCH;
            end
            S_LEA: begin
                gate_marmux = 1'b1;
                addr2mux    = 2'b10;
                ld_reg      = 1'b1;
                w_next      = S_FETCH;
            end
            S_JSR_SAVE: begin
                gate_pc = 1'b1;
                ld_reg  = 1'b1;
                dr_sel  = 1'b1;
                w_next  = S_JSR_PC;
            end
            S_JSR_PC: begin
                // JSR (ir[11]=1) adds off11 to PC; JSRR jumps to BaseR
                ld_pc = 1'b1;
                pcmux = 2'b01;
                if (ir[11]) begin
                    addr2mux = 2'b11;
                end else begin
                    addr1mux = 1'b1;
                    sr1      = 1'b1;
                end
                w_next = S_FETCH;
            end
            S_JMP: begin
                ld_pc    = 1'b1;
                pcmux    = 2'b01;
                addr1mux = 1'b1;
                sr1      = 1'b1;
                w_next   = S_FETCH;
            end
            S_BR: begin
                w_next = ben ? S_BR_TAKE : S_FETCH;
            end
            S_BR_TAKE: begin
                ld_pc    = 1'b1;
                pcmux    = 2'b01;
                addr2mux = 2'b10;
                w_next   = S_FETCH;
            end
            S_PAUSE1: begin
                ld_led = 1'b1;
                if (continue_i) w_next = S_PAUSE2;
            end
            S_PAUSE2: begin
                ld_led = 1'b1;
                if (!continue_i) w_next = S_FETCH;
            end
            default: begin
                w_next = S_HALTED;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_slc3_control_fsm.sv
//------------------------------------------------------------------------------
// Module      : tb_slc3_control_fsm
// Description : Directed bench for slc3_control_fsm. Four instances share the
//               stimulus: [0] MEM_WAIT=3, [1] MEM_WAIT=1, [2] ready mode,
//               [3] PAUSE_EN=0. Outputs are packed into one 24-bit word each.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_slc3_control_fsm;

    // Packed output word layout
    // [0]ld_mar [1]ld_mdr [2]ld_ir [3]ld_pc [4]ld_led [5]ld_reg [6]ld_cc
    // [7]gate_pc [8]gate_mdr [9]gate_alu [10]gate_marmux [12:11]pcmux
    // [14:13]ALUK [15]sr1 [16]sr2mux [17]addr1mux [19:18]addr2mux
    // [20]dr_sel [21]mem_mem_ena [22]mem_wr_ena [23]illegal_o
    localparam logic [23:0] E_ZERO  = 24'h000000;
    localparam logic [23:0] E_FETCH = 24'h000089;
    localparam logic [23:0] E_MEM   = 24'h200002;
    localparam logic [23:0] E_LIR   = 24'h000104;
    localparam logic [23:0] E_DEC   = 24'h000000;
    localparam logic [23:0] E_ADD   = 24'h008260;
    localparam logic [23:0] E_ANDI  = 24'h01A260;
    localparam logic [23:0] E_RADDR = 24'h068401;
    localparam logic [23:0] E_LDWB  = 24'h000160;
    localparam logic [23:0] E_STMDR = 24'h006202;
    localparam logic [23:0] E_STWR  = 24'h600000;
    localparam logic [23:0] E_BR    = 24'h000000;
    localparam logic [23:0] E_BRT   = 24'h080808;
    localparam logic [23:0] E_PAUSE = 24'h000010;
    localparam logic [23:0] E_ILL   = 24'h800000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ir = 16'h0000;
    logic        ben = 1'b0;
    logic        continue_i = 1'b0;
    logic        run_i = 1'b0;
    logic        mem_rdy_i = 1'b1;

    wire  [23:0] w_o [4];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        slc3_control_fsm #(
            .MEM_WAIT ((g == 1) ? 1 : 3),
            .MEM_MODE ((g == 2) ? 1 : 0),
            .PAUSE_EN ((g == 3) ? 0 : 1)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .ir          (ir),
            .ben         (ben),
            .continue_i  (continue_i),
            .run_i       (run_i),
            .mem_rdy_i   (mem_rdy_i),
            .ld_mar      (w_o[g][0]),
            .ld_mdr      (w_o[g][1]),
            .ld_ir       (w_o[g][2]),
            .ld_pc       (w_o[g][3]),
            .ld_led      (w_o[g][4]),
            .ld_reg      (w_o[g][5]),
            .ld_cc       (w_o[g][6]),
            .gate_pc     (w_o[g][7]),
            .gate_mdr    (w_o[g][8]),
            .gate_alu    (w_o[g][9]),
            .gate_marmux (w_o[g][10]),
            .pcmux       (w_o[g][12:11]),
            .ALUK        (w_o[g][14:13]),
            .sr1         (w_o[g][15]),
            .sr2mux      (w_o[g][16]),
            .addr1mux    (w_o[g][17]),
            .addr2mux    (w_o[g][19:18]),
            .dr_sel      (w_o[g][20]),
            .mem_mem_ena (w_o[g][21]),
            .mem_wr_ena  (w_o[g][22]),
            .illegal_o   (w_o[g][23])
        );
    end

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Return every instance to HALTED with quiet inputs
    task automatic do_reset();
        reset      = 1'b1;
        run_i      = 1'b0;
        continue_i = 1'b0;
        ben        = 1'b0;
        mem_rdy_i  = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        for (int g = 0; g < 4; g++) begin
            n_chk++;
            if (w_o[g] !== E_ZERO) begin
                $display("FAIL reset_state[%0d]: got %h expected %h", g, w_o[g], E_ZERO);
                n_fail++;
            end
        end
        // No run_i: must stay halted
        step();
        step();
        n_chk++;
        if (w_o[0] !== E_ZERO) begin
            $display("FAIL halted_idle: got %h expected %h", w_o[0], E_ZERO);
            n_fail++;
        end
    endtask

    // ADD register form followed by AND immediate form, MEM_WAIT=3
    task automatic test_add_and();
        logic [23:0] ex [15];
        ex = '{E_FETCH, E_MEM, E_MEM, E_MEM, E_LIR, E_DEC, E_ADD,
               E_FETCH, E_MEM, E_MEM, E_MEM, E_LIR, E_DEC, E_ANDI, E_FETCH};
        do_reset();
        ir    = 16'h1042;
        run_i = 1'b1;
        step();
        run_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            n_chk++;
            if (w_o[0] !== ex[i]) begin
                $display("FAIL add_and[%0d]: got %h expected %h", i, w_o[0], ex[i]);
                n_fail++;
            end
            if (i == 7) ir = 16'h5062;
            step();
        end
    endtask

    // LDR with single-cycle memory
    task automatic test_ldr_w1();
        logic [23:0] ex [8];
        ex = '{E_FETCH, E_MEM, E_LIR, E_DEC, E_RADDR, E_MEM, E_LDWB, E_FETCH};
        do_reset();
        ir    = 16'h6283;
        run_i = 1'b1;
        step();
        run_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (w_o[1] !== ex[i]) begin
                $display("FAIL ldr_w1[%0d]: got %h expected %h", i, w_o[1], ex[i]);
                n_fail++;
            end
            step();
        end
    endtask

    // STR in ready mode: store held while mem_rdy_i is low for 5 cycles
    task automatic test_str_ready();
        logic [23:0] ex [13];
        ex = '{E_FETCH, E_MEM, E_LIR, E_DEC, E_RADDR, E_STMDR,
               E_STWR, E_STWR, E_STWR, E_STWR, E_STWR, E_STWR, E_FETCH};
        do_reset();
        ir    = 16'h7283;
        run_i = 1'b1;
        step();
        run_i = 1'b0;
        for (int i = 0; i < 13; i++) begin
            n_chk++;
            if (w_o[2] !== ex[i]) begin
                $display("FAIL str_ready[%0d]: got %h expected %h", i, w_o[2], ex[i]);
                n_fail++;
            end
            if (i == 5)  mem_rdy_i = 1'b0;
            if (i == 11) mem_rdy_i = 1'b1;
            step();
        end
    endtask

    // BR not taken then taken; run_i held high throughout must be ignored
    task automatic test_branch();
        logic [23:0] ex [16];
        ex = '{E_FETCH, E_MEM, E_MEM, E_MEM, E_LIR, E_DEC, E_BR, E_FETCH,
               E_MEM, E_MEM, E_MEM, E_LIR, E_DEC, E_BR, E_BRT, E_FETCH};
        do_reset();
        ir    = 16'h0E05;
        run_i = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            n_chk++;
            if (w_o[0] !== ex[i]) begin
                $display("FAIL branch[%0d]: got %h expected %h", i, w_o[0], ex[i]);
                n_fail++;
            end
            if (i == 7) ben = 1'b1;
            step();
        end
        run_i = 1'b0;
        ben   = 1'b0;
    endtask

    // PSE pauses on instance 0 and is illegal on instance 3
    task automatic test_pause();
        logic [23:0] ex_p [13];
        logic [23:0] ex_i [13];
        ex_p = '{E_FETCH, E_MEM, E_MEM, E_MEM, E_LIR, E_DEC, E_PAUSE,
                 E_PAUSE, E_PAUSE, E_PAUSE, E_PAUSE, E_PAUSE, E_FETCH};
        ex_i = '{E_FETCH, E_MEM, E_MEM, E_MEM, E_LIR, E_ILL, E_FETCH,
                 E_MEM, E_MEM, E_MEM, E_LIR, E_ILL, E_FETCH};
        do_reset();
        ir    = 16'hD000;
        run_i = 1'b1;
        step();
        run_i = 1'b0;
        for (int i = 0; i < 13; i++) begin
            n_chk++;
            if (w_o[0] !== ex_p[i]) begin
                $display("FAIL pause[%0d]: got %h expected %h", i, w_o[0], ex_p[i]);
                n_fail++;
            end
            n_chk++;
            if (w_o[3] !== ex_i[i]) begin
                $display("FAIL pse_illegal[%0d]: got %h expected %h", i, w_o[3], ex_i[i]);
                n_fail++;
            end
            if (i == 8)  continue_i = 1'b1;
            if (i == 11) continue_i = 1'b0;
            step();
        end
    endtask

    // Asynchronous reset during the second MEM_RD cycle
    task automatic test_reset_mid();
        do_reset();
        ir    = 16'h1042;
        run_i = 1'b1;
        step();
        run_i = 1'b0;
        step();
        step();
        n_chk++;
        if (w_o[0] !== E_MEM) begin
            $display("FAIL mid_pre_reset: got %h expected %h", w_o[0], E_MEM);
            n_fail++;
        end
        #2;
        reset = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            n_chk++;
            if (w_o[g] !== E_ZERO) begin
                $display("FAIL mid_async_reset[%0d]: got %h expected %h", g, w_o[g], E_ZERO);
                n_fail++;
            end
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if (w_o[0] !== E_ZERO) begin
                $display("FAIL post_reset_idle[%0d]: got %h expected %h", i, w_o[0], E_ZERO);
                n_fail++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_and();
        test_ldr_w1();
        test_str_ready();
        test_branch();
        test_pause();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/slc3_control_fsm.md
Name: slc3_control_fsm

Overview:
- Parametrised SLC-3 control unit, successor to the fixed-timing control FSM.
- Sequences fetch, decode and execute for the SLC-3 subset (ADD, AND, NOT, LDR, STR, JSR, JMP, BR, PSE) and adds LD, ST and LEA.
- Memory access length is set by a parameter, or by a ready handshake for MMIO-backed memory.
- Sits between IR/BEN and the datapath. All outputs are registered-state decodes (Moore).

Parameters:
- MEM_WAIT, 3: cycles a memory access holds mem_mem_ena in fixed mode. Legal range 1..15.
- MEM_MODE, 0: 0 = fixed MEM_WAIT cycles; 1 = hold the access until mem_rdy_i is high.
- PAUSE_EN, 1: 1 = PSE opcode (1101) pauses with ld_led; 0 = PSE treated as illegal.

Ports:
- clk  in  1  system clock; all transitions on the rising edge.
- reset  in  1  asynchronous, active-high; forces HALTED.
- ir  in  16  instruction register.
- ben  in  1  branch enable, sampled in BR.
- continue_i  in  1  pause release (level).
- run_i  in  1  start from HALTED.
- mem_rdy_i  in  1  memory done; used only when MEM_MODE=1.
- ld_mar, ld_mdr, ld_ir, ld_pc, ld_led, ld_reg, ld_cc  out  1 each  register loads.
- gate_pc, gate_mdr, gate_alu, gate_marmux  out  1 each  bus drivers; at most one high per cycle.
- pcmux  out  2  00 = PC+1, 01 = address adder, 10 = bus.
- ALUK  out  2  00 = ADD, 01 = AND, 10 = NOT, 11 = PASS A.
- sr1  out  1  0 = IR[11:9], 1 = IR[8:6].
- sr2mux  out  1  0 = SR2 register, 1 = sext(IR[4:0]).
- addr1mux  out  1  0 = PC, 1 = SR1.
- addr2mux  out  2  00 = 0, 01 = off6, 10 = off9, 11 = off11.
- dr_sel  out  1  0 = IR[11:9], 1 = R7.
- mem_mem_ena, mem_wr_ena  out  1 each  memory enable / write.
- illegal_o  out  1  one-cycle pulse on an undecodable opcode.

Behaviour:
- Reset: state = HALTED, wait counter = 0, every output 0. Async assertion mid-access aborts the access; outputs go 0 in the same cycle.
- Defaults: every output 0 unless listed for a state.
- Counter: one 4-bit wait counter is shared by MEM_RD, LD_RD and ST_WR.
- Memory state exit:
  - Fixed mode: the counter loads 0 on entry and the state exits after MEM_WAIT cycles in the state.
  - Ready mode: the state exits on the first cycle with mem_rdy_i = 1, checked from the first cycle. mem_rdy_i high on the entry cycle gives a 1-cycle access.
- States and outputs:
  - HALTED: idle; run_i = 1 goes to FETCH.
  - FETCH: gate_pc, ld_mar, ld_pc, pcmux = 00. Next MEM_RD.
  - MEM_RD: mem_mem_ena, ld_mdr. Exit per the rule above to LOAD_IR.
  - LOAD_IR: gate_mdr, ld_ir. Next DECODE.
  - DECODE: no outputs. Branches on ir[15:12].
  - ADD/AND: gate_alu, ld_reg, ld_cc, sr1 = 1, sr2mux = ir[5], ALUK = 00 for ADD, 01 for AND. Next FETCH.
  - NOT: gate_alu, ld_reg, ld_cc, sr1 = 1, ALUK = 10. Next FETCH.
  - LDR / STR address: gate_marmux, ld_mar, addr1mux = 1, addr2mux = 01, sr1 = 1.
  - LD / ST address: as LDR / STR address but addr1mux = 0, addr2mux = 10.
  - LD_RD: mem_mem_ena, ld_mdr (wait rule). Next LD_WB.
  - LD_WB: gate_mdr, ld_reg, ld_cc. Next FETCH.
  - ST_MDR: sr1 = 0, ALUK = 11, gate_alu, ld_mdr. Next ST_WR.
  - ST_WR: mem_mem_ena, mem_wr_ena (wait rule). Next FETCH.
  - LEA: gate_marmux, addr1mux = 0, addr2mux = 10, ld_reg. ld_cc = 0. Next FETCH.
  - JSR_SAVE: gate_pc, ld_reg, dr_sel = 1.
    - ir[11] = 1: next JSR_PC with pcmux = 01, addr1mux = 0, addr2mux = 11.
    - ir[11] = 0: next JSR_PC with pcmux = 01, addr1mux = 1, addr2mux = 00, sr1 = 1.
    - JSR_PC asserts ld_pc. Next FETCH.
  - JMP: ld_pc, pcmux = 01, addr1mux = 1, addr2mux = 00, sr1 = 1. Next FETCH.
  - BR: ben = 1 goes to BR_TAKE, else FETCH.
  - BR_TAKE: ld_pc, pcmux = 01, addr1mux = 0, addr2mux = 10. Next FETCH.
  - PAUSE1: ld_led. continue_i = 1 goes to PAUSE2.
  - PAUSE2: ld_led. continue_i = 0 goes to FETCH.
  - Illegal opcode (including PSE when PAUSE_EN = 0): illegal_o = 1 in DECODE, next FETCH.
- Boundaries:
  - run_i is ignored outside HALTED.
  - continue_i held high through PAUSE2 keeps the FSM in PAUSE2.
  - MEM_MODE = 1 with mem_rdy_i stuck low stalls indefinitely; mem_mem_ena stays high.
  - Counter must not wrap at MEM_WAIT = 15.

Test Plan:
- Reset, run_i pulse, MEM_WAIT=3, ir=16'h1042 (ADD R0,R1,R2) -> FETCH, 3×MEM_RD, LOAD_IR, DECODE, ADD with gate_alu=ld_reg=ld_cc=1, sr2mux=0; FETCH 8 cycles after run_i.
- MEM_WAIT=1, ir=16'h6283 (LDR) -> mem_mem_ena high exactly 1 cycle in fetch and 1 cycle in LD_RD; LD_WB asserts gate_mdr, ld_reg.
- MEM_MODE=1, ir=16'h7283 (STR), mem_rdy_i low 5 cycles then high -> mem_wr_ena high 6 consecutive cycles, then FETCH.
- ir=16'h0E05 (BR) with ben=0 -> BR then FETCH, ld_pc never asserted. Same with ben=1 -> BR_TAKE with ld_pc=1, pcmux=01, addr2mux=10.
- ir=16'hD000, PAUSE_EN=1 -> ld_led held until continue_i rises then falls. With PAUSE_EN=0 -> illegal_o single pulse, then FETCH.
- Assert reset during the second MEM_RD cycle -> all outputs 0 immediately; no activity until run_i.
